// File: rtl/mips32_fetch_queue_if.sv
// Memory-request and decode-handshake bundle of the MIPS32 fetch queue.
// The master side is the fetch queue; the slave side is memory plus the ID stage.
interface mips32_fetch_queue_if #(
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              deq_valid;
  logic              deq_ready;
  logic [31:0]       deq_ir;
  logic [31:0]       deq_npc;

  modport master (
    output mem_rd_en, mem_addr, deq_valid, deq_ir, deq_npc,
    input  mem_rdata, deq_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, deq_valid, deq_ir, deq_npc,
    output mem_rdata, deq_ready
  );
endinterface

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch queue: issues word reads and buffers {ir, npc} pairs for decode.
// Optional FQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk1,
  input  logic                   reset,
  mips32_fetch_queue_if.master   bus,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NPC_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [CNT_W:0]    DEPTH_V    = (CNT_W + 1)'(DEPTH);

  // npc keeps the carry out of the PC so the top word reports 2**ADDR_W.
  function automatic logic [NPC_W-1:0] next_npc(input logic [ADDR_W-1:0] pc);
    return {1'b0, pc} + NPC_W'(1'b1);
  endfunction

  function automatic logic [31:0] zext_npc(input logic [NPC_W-1:0] npc);
    return {{(32 - NPC_W){1'b0}}, npc};
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [NPC_W-1:0]  tag_npc_q, tag_npc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halted_q, halted_d;
  logic [31:0]       last_ir_q, last_ir_d;
  logic [31:0]       last_npc_q, last_npc_d;
  logic [31:0]       ir_mem_q  [DEPTH];
  logic [31:0]       ir_mem_d  [DEPTH];
  logic [NPC_W-1:0]  npc_mem_q [DEPTH];
  logic [NPC_W-1:0]  npc_mem_d [DEPTH];

  logic [CNT_W:0]    occupancy_s;
  logic              issue_s;
  logic              resp_valid_s;
  logic              fifo_empty_s;
  logic              bypass_s;
  logic              head_valid_s;
  logic [31:0]       head_ir_s;
  logic [31:0]       head_npc_s;
  logic              deq_fire_s;
  logic              pop_s;
  logic              enq_s;

  // Issue decision, head selection and handshake qualification.
  always_comb begin
    occupancy_s  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue_s      = !reset && !halt && !redirect && (occupancy_s < DEPTH_V);
    resp_valid_s = inflight_q && !redirect;
    fifo_empty_s = (count_q == {CNT_W{1'b0}});
`ifdef FQ_BYPASS_EN
    bypass_s     = fifo_empty_s && resp_valid_s;
`else
    bypass_s     = 1'b0;
`endif
    if (!fifo_empty_s) begin
      head_valid_s = 1'b1;
      head_ir_s    = ir_mem_q[rd_ptr_q];
      head_npc_s   = zext_npc(npc_mem_q[rd_ptr_q]);
    end else if (bypass_s) begin
      head_valid_s = 1'b1;
      head_ir_s    = bus.mem_rdata;
      head_npc_s   = zext_npc(tag_npc_q);
    end else begin
      // Empty: present the last value shown so decode sees stable data.
      head_valid_s = 1'b0;
      head_ir_s    = last_ir_q;
      head_npc_s   = last_npc_q;
    end
    deq_fire_s = head_valid_s && bus.deq_ready && !redirect;
    pop_s      = deq_fire_s && !fifo_empty_s;
    enq_s      = resp_valid_s && !(bypass_s && deq_fire_s);
  end

  // Next-state for PC, pending tag, pointers, occupancy and halt status.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue_s;
    tag_npc_d  = tag_npc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_ir_d  = head_ir_s;
    last_npc_d = head_npc_s;
    ir_mem_d   = ir_mem_q;
    npc_mem_d  = npc_mem_q;

    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue_s) begin
      pc_d      = pc_q + ADDR_W'(1'b1);
      tag_npc_d = next_npc(pc_q);
    end else begin
      pc_d = pc_q;
    end

    if (enq_s) begin
      ir_mem_d[wr_ptr_q]  = bus.mem_rdata;
      npc_mem_d[wr_ptr_q] = tag_npc_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (redirect) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = {CNT_W{1'b0}};
    end else begin
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
      case ({enq_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end

    halted_d = halted_q || (halt && !inflight_d);
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC_V;
      inflight_q <= 1'b0;
      tag_npc_q  <= {NPC_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      halted_q   <= 1'b0;
      last_ir_q  <= 32'h0000_0000;
      last_npc_q <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= 32'h0000_0000;
        npc_mem_q[i] <= {NPC_W{1'b0}};
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_npc_q  <= tag_npc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      last_ir_q  <= last_ir_d;
      last_npc_q <= last_npc_d;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= ir_mem_d[i];
        npc_mem_q[i] <= npc_mem_d[i];
      end
    end
  end

  assign bus.mem_rd_en = issue_s;
  assign bus.mem_addr  = pc_q;
  assign bus.deq_valid = head_valid_s;
  assign bus.deq_ir    = head_ir_s;
  assign bus.deq_npc   = head_npc_s;
  assign count         = count_q;
  assign halted        = halted_q;
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue: per-cycle vector table plus a PC wrap-around sequence.
module tb_mips32_fetch_queue;
  localparam logic [31:0] D = 32'h1000_0000;

  typedef struct {
    logic        rst, rdy, redir, hlt;
    logic [9:0]  rpc;
    logic        exp_en;
    logic [9:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ir, exp_npc;
    logic [2:0]  exp_cnt;
    logic        exp_halted;
  } vec_t;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic [31:0] mem [0:1023];

  logic       rst0 = 1'b1, redir0 = 1'b0, halt0 = 1'b0;
  logic [9:0] rpc0 = 10'h000;
  logic [2:0] count0;
  logic       halted0;
  mips32_fetch_queue_if #(.ADDR_W(10)) bus0();

  logic       rst1 = 1'b1, redir1 = 1'b0, halt1 = 1'b0;
  logic [9:0] rpc1 = 10'h000;
  logic [2:0] count1;
  logic       halted1;
  mips32_fetch_queue_if #(.ADDR_W(10)) bus1();

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(0)) dut0 (
    .clk1(clk1), .reset(rst0), .bus(bus0), .redirect(redir0), .redirect_pc(rpc0),
    .halt(halt0), .count(count0), .halted(halted0)
  );

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(10'h3FE)) dut1 (
    .clk1(clk1), .reset(rst1), .bus(bus1), .redirect(redir1), .redirect_pc(rpc1),
    .halt(halt1), .count(count1), .halted(halted1)
  );

  always @(posedge clk1) if (bus0.mem_rd_en) bus0.mem_rdata <= mem[bus0.mem_addr];
  always @(posedge clk1) if (bus1.mem_rd_en) bus1.mem_rdata <= mem[bus1.mem_addr];

  int   total  = 0;
  int   passed = 0;
  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic add(input int rst, input int rdy, input int rd, input int hl, input int rpc,
                     input int en, input int addr, input int valid, input logic [31:0] ir,
                     input int npc, input int cnt, input int hd);
    vec_t v;
    v.rst = rst[0]; v.rdy = rdy[0]; v.redir = rd[0]; v.hlt = hl[0]; v.rpc = rpc[9:0];
    v.exp_en = en[0]; v.exp_addr = addr[9:0]; v.exp_valid = valid[0]; v.exp_ir = ir;
    v.exp_npc = npc; v.exp_cnt = cnt[2:0]; v.exp_halted = hd[0];
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not yet printed");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = D + i;
    bus0.deq_ready = 1'b0;
    bus1.deq_ready = 1'b1;

    // Reset, then stream with decode always ready.
    add(1,0,0,0,0,     0,0,0,0,0,0,0);
    add(1,0,0,0,0,     0,0,0,0,0,0,0);
    add(0,1,0,0,0,     1,0,0,0,0,0,0);
    add(0,1,0,0,0,     1,1,0,0,0,0,0);
    for (int k = 4; k <= 11; k++) add(0,1,0,0,0, 1,k-2,1,D+k-4,k-3,1,0);
    // Backpressure for ten cycles: queue fills, fetching stops.
    add(0,0,0,0,0,     1,10,1,D+8,9,1,0);
    add(0,0,0,0,0,     1,11,1,D+8,9,2,0);
    add(0,0,0,0,0,     0,12,1,D+8,9,3,0);
    for (int k = 15; k <= 21; k++) add(0,0,0,0,0, 0,12,1,D+8,9,4,0);
    // Release: buffered words drain in order, fetching resumes at 12.
    add(0,1,0,0,0,     0,12,1,D+8,9,4,0);
    add(0,1,0,0,0,     1,12,1,D+9,10,3,0);
    add(0,1,0,0,0,     1,13,1,D+10,11,2,0);
    for (int k = 25; k <= 27; k++) add(0,1,0,0,0, 1,k-11,1,D+k-14,k-13,2,0);
    // Redirect to 0x3F0 with a response in flight and decode ready.
    add(0,1,1,0,10'h3F0, 0,17,1,D+14,15,2,0);
    add(0,1,0,0,0,     1,10'h3F0,0,D+14,15,0,0);
    add(0,1,0,0,0,     1,10'h3F1,0,D+14,15,0,0);
    add(0,1,0,0,0,     1,10'h3F2,1,D+10'h3F0,10'h3F1,1,0);
    add(0,1,0,0,0,     1,10'h3F3,1,D+10'h3F1,10'h3F2,1,0);
    // Reset asserted mid-stream between edges, then refill two entries.
    add(1,0,0,0,0,     0,0,0,0,0,0,0);
    add(0,0,0,0,0,     1,0,0,0,0,0,0);
    add(0,0,0,0,0,     1,1,0,0,0,0,0);
    add(0,0,0,0,0,     1,2,1,D,1,1,0);
    // Halt with two buffered and one in flight: exactly three drain.
    add(0,0,0,1,0,     0,3,1,D,1,2,0);
    add(0,1,0,1,0,     0,3,1,D,1,3,1);
    add(0,1,0,1,0,     0,3,1,D+1,2,2,1);
    add(0,1,0,1,0,     0,3,1,D+2,3,1,1);
    add(0,1,0,1,0,     0,3,0,D+2,3,0,1);
    // Redirect during halt moves PC without issuing; halted is sticky.
    add(0,1,1,1,10'h100, 0,3,0,D+2,3,0,1);
    add(0,1,0,1,0,     0,10'h100,0,D+2,3,0,1);
    add(0,1,0,0,0,     1,10'h100,0,D+2,3,0,1);
    add(0,1,0,0,0,     1,10'h101,0,D+2,3,0,1);
    add(0,1,0,0,0,     1,10'h102,1,D+10'h100,10'h101,1,1);

    foreach (vecs[i]) begin
      @(posedge clk1); #1;
      rst0 = vecs[i].rst; bus0.deq_ready = vecs[i].rdy;
      redir0 = vecs[i].redir; rpc0 = vecs[i].rpc; halt0 = vecs[i].hlt;
      #3;
      check("mem_rd_en", i, 32'(bus0.mem_rd_en), 32'(vecs[i].exp_en));
      check("mem_addr",  i, 32'(bus0.mem_addr),  32'(vecs[i].exp_addr));
      check("deq_valid", i, 32'(bus0.deq_valid), 32'(vecs[i].exp_valid));
      check("deq_ir",    i, bus0.deq_ir,         vecs[i].exp_ir);
      check("deq_npc",   i, bus0.deq_npc,        vecs[i].exp_npc);
      check("count",     i, 32'(count0),         32'(vecs[i].exp_cnt));
      check("halted",    i, 32'(halted0),        32'(vecs[i].exp_halted));
    end

    // Wrap-around from RESET_PC=0x3FE: npc of 0x3FF is 0x400.
    @(posedge clk1); #1; rst1 = 1'b0; #3;
    check("wrap_en",    100, 32'(bus1.mem_rd_en), 32'd1);
    check("wrap_addr",  100, 32'(bus1.mem_addr),  32'h3FE);
    @(posedge clk1); #4;
    check("wrap_addr",  101, 32'(bus1.mem_addr),  32'h3FF);
    check("wrap_valid", 101, 32'(bus1.deq_valid), 32'd0);
    @(posedge clk1); #4;
    check("wrap_addr",  102, 32'(bus1.mem_addr),  32'h000);
    check("wrap_ir",    102, bus1.deq_ir,         D + 32'h3FE);
    check("wrap_npc",   102, bus1.deq_npc,        32'h3FF);
    @(posedge clk1); #4;
    check("wrap_addr",  103, 32'(bus1.mem_addr),  32'h001);
    check("wrap_ir",    103, bus1.deq_ir,         D + 32'h3FF);
    check("wrap_npc",   103, bus1.deq_npc,        32'h400);
    @(posedge clk1); #4;
    check("wrap_ir",    104, bus1.deq_ir,         D);
    check("wrap_npc",   104, bus1.deq_npc,        32'h001);
    check("wrap_count", 104, 32'(count1),         32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips32_fetch_queue.md
Name: mips32_fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the MIPS32 ID stage.
- Issues word reads to the shared 1K x 32 memory and buffers fetched instructions, paired with their next-PC values, in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Flushes and refetches on a branch redirect from EX/MEM, and stops fetching on halt.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 10, word-address width of instruction memory (PC wraps at 2**ADDR_W)
RESET_PC, 0, PC value loaded on reset

Ports:
clk1  in  1  single clock; all state updates on posedge clk1
reset  in  1  asynchronous, active-high reset
mem_rd_en  out  1  read request to memory this cycle
mem_addr  out  ADDR_W  word address of request (= PC)
mem_rdata  in  32  read data; valid exactly 1 cycle after mem_rd_en
redirect  in  1  branch taken; flush and restart at redirect_pc
redirect_pc  in  ADDR_W  branch target word address
halt  in  1  stop issuing new fetches (level)
deq_valid  out  1  head entry available to ID
deq_ready  in  1  ID accepts head entry
deq_ir  out  32  instruction at head
deq_npc  out  32  zero-extended address+1 of head instruction
count  out  log2(DEPTH)+1  occupied entries
halted  out  1  halt seen and no fetch in flight

Behaviour:
- Reset (async): PC=RESET_PC, FIFO empty, count=0, inflight=0, mem_rd_en=0, deq_valid=0, deq_ir=0, deq_npc=0, halted=0.
- Issue rule: mem_rd_en=1 when !reset, !halt, !redirect, and (count + inflight) < DEPTH. mem_addr=PC. On issue, PC <= PC+1 (mod 2**ADDR_W), inflight <= 1, and the pending tag records {PC, PC+1}.
- Response: the cycle after an issue with inflight=1, mem_rdata is written to the tail with npc = tagged PC+1. Memory latency is exactly 1; at most 1 request is outstanding per cycle, so issue is back-to-back (one per cycle, throughput 1).
- Dequeue: a transfer occurs when deq_valid && deq_ready; the head pointer advances. Simultaneous enqueue and dequeue leaves count unchanged. deq_ir/deq_npc are driven combinationally from the head entry; they hold while deq_valid && !deq_ready.
- Full: when count + inflight == DEPTH, issue is suppressed. With count==DEPTH and no dequeue, nothing is lost.
- Empty: deq_valid=0. deq_ir/deq_npc are don't-care and are required to hold their last value.
- Redirect (highest priority): in the same cycle, the FIFO is emptied (count=0 next cycle) and any response returning this cycle or next for a pre-redirect request is discarded. PC <= redirect_pc; no issue that cycle. The first issue at redirect_pc occurs the following cycle. A dequeue asserted in the redirect cycle is ignored (no transfer counted).
- Halt: issuing stops the cycle halt is seen. An in-flight response still enqueues. The FIFO drains normally. halted=1 once halt && inflight==0; it stays set until reset. Redirect during halt updates PC but does not issue.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. count is computed separately from the pointers, so full and empty are distinguished.
- Reset mid-operation: all state clears immediately. A memory response arriving after reset deassertion is ignored because inflight=0.

Optional Feature:
FQ_BYPASS_EN
- Defined: when the FIFO is empty and a valid response arrives, deq_valid=1 in the same cycle with deq_ir=mem_rdata and deq_npc from the pending tag. If deq_ready is high, the entry is consumed without being written. Fetch-to-decode latency is 1 cycle. Redirect still suppresses the bypass.
- Undefined: responses always enqueue first, so latency is 2 cycles; deq_* is always registered or FIFO-sourced.

Test Plan:
- Reset then stream: memory words 0..7 = 0x1000_0000+i, deq_ready=1 → deq_ir sequence 0x1000_0000.. in order, deq_npc 1..8, one per cycle after initial latency, no gaps.
- Backpressure: deq_ready=0 for 10 cycles → count reaches 4, mem_rd_en=0 while full. Then deq_ready=1 → 4 buffered words followed by addr 4, 5, ... with none lost or duplicated.
- Redirect: after 3 fetches, pulse redirect with redirect_pc=0x3F0 → next dequeued deq_ir=Mem[0x3F0] with deq_npc=0x3F1. No pre-redirect word appears after the pulse, including the one in flight.
- Wrap-around: RESET_PC=0x3FE → fetch addresses 0x3FE, 0x3FF, 0x000. deq_npc for 0x3FF = 0x400 (zero-extended ADDR_W+1 result).
- Halt: assert halt with 2 entries buffered and 1 in flight → mem_rd_en drops that cycle, halted=1 next cycle, exactly 3 instructions dequeue, then deq_valid=0.
- Async reset mid-stream: assert reset between clock edges → deq_valid, count, and mem_rd_en go 0 immediately. After release, fetch restarts at RESET_PC.
